// File: rtl/stage_execute_md.sv
// Execute-stage multiply/divide responder: owns HI/LO, computes results at issue and
// commits them after a fixed busy window, stalling later HI/LO instructions meanwhile.
`ifndef ALU_OP_LEN
`define ALU_OP_LEN 5
`endif
`ifndef ALU_OP_MULT
`define ALU_OP_MULT  5'd16
`define ALU_OP_MULTU 5'd17
`define ALU_OP_DIV   5'd18
`define ALU_OP_DIVU  5'd19
`define ALU_OP_MFHI  5'd20
`define ALU_OP_MFLO  5'd21
`define ALU_OP_MTHI  5'd22
`define ALU_OP_MTLO  5'd23
`endif

module stage_execute_md #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [`ALU_OP_LEN-1:0] op,
    input  logic                   op_valid,
    input  logic                   cancel,
    input  logic [31:0]            rs_data,
    input  logic [31:0]            rt_data,
    output logic                   md_stall,
    output logic                   busy,
    output logic [31:0]            hi,
    output logic [31:0]            lo,
    output logic [31:0]            read_data
);

    localparam logic [`ALU_OP_LEN-1:0] OP_MULT  = `ALU_OP_MULT;
    localparam logic [`ALU_OP_LEN-1:0] OP_MULTU = `ALU_OP_MULTU;
    localparam logic [`ALU_OP_LEN-1:0] OP_DIV   = `ALU_OP_DIV;
    localparam logic [`ALU_OP_LEN-1:0] OP_DIVU  = `ALU_OP_DIVU;
    localparam logic [`ALU_OP_LEN-1:0] OP_MFHI  = `ALU_OP_MFHI;
    localparam logic [`ALU_OP_LEN-1:0] OP_MFLO  = `ALU_OP_MFLO;
    localparam logic [`ALU_OP_LEN-1:0] OP_MTHI  = `ALU_OP_MTHI;
    localparam logic [`ALU_OP_LEN-1:0] OP_MTLO  = `ALU_OP_MTLO;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]  counter;
    logic [31:0] pending_hi;
    logic [31:0] pending_lo;
    logic        pending_we;

    logic        md_class;
    logic        is_mult;
    logic        is_div;
    logic        accept;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [63:0]        mult_result;

    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        md_class = 1'b0;
        is_mult  = 1'b0;
        is_div   = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: begin
                md_class = 1'b1;
                is_mult  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                md_class = 1'b1;
                is_div   = 1'b1;
            end
            OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: md_class = 1'b1;
            default: md_class = 1'b0;
        endcase
    end

    assign busy     = (counter != 4'd0);
    assign md_stall = op_valid & md_class & busy;
    assign accept   = op_valid & md_class & ~busy & ~cancel;

    always_comb begin
        read_data = 32'd0;
        if (op == OP_MFHI)
            read_data = hi;
        else if (op == OP_MFLO)
            read_data = lo;
    end

    assign prod_s      = $signed(rs_data) * $signed(rt_data);
    assign prod_u      = {32'd0, rs_data} * {32'd0, rt_data};
    assign mult_result = (op == OP_MULT) ? prod_s : prod_u;

    // Signed divide works on magnitudes so 0x80000000 / -1 yields 0x80000000 with no overflow trap.
    assign div_signed = (op == OP_DIV);
    assign a_neg      = div_signed & rs_data[31];
    assign b_neg      = div_signed & rt_data[31];
    assign a_mag      = a_neg ? (32'd0 - rs_data) : rs_data;
    assign b_mag      = b_neg ? (32'd0 - rt_data) : rt_data;
    assign b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi         <= 32'd0;
            lo         <= 32'd0;
            counter    <= 4'd0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            pending_we <= 1'b0;
        end else begin
            if (counter != 4'd0) begin
                counter <= counter - 4'd1;
                if (counter == 4'd1 && pending_we) begin
                    hi <= pending_hi;
                    lo <= pending_lo;
                end
            end
            // accept implies counter==0, so these never collide with the commit above.
            if (accept) begin
                if (is_mult) begin
                    pending_hi <= mult_result[63:32];
                    pending_lo <= mult_result[31:0];
                    pending_we <= 1'b1;
                    counter    <= MULT_LOAD;
                end else if (is_div) begin
                    pending_hi <= rem;
                    pending_lo <= quot;
                    pending_we <= (rt_data != 32'd0);
                    counter    <= DIV_LOAD;
                end else if (op == OP_MTHI) begin
                    hi <= rs_data;
                end else if (op == OP_MTLO) begin
                    lo <= rs_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_execute_md.sv
// Directed bench for stage_execute_md: table of HI/LO operations plus hand sequences
// for stall, cancel and mid-operation reset.
`ifndef ALU_OP_LEN
`define ALU_OP_LEN 5
`endif
`ifndef ALU_OP_MULT
`define ALU_OP_MULT  5'd16
`define ALU_OP_MULTU 5'd17
`define ALU_OP_DIV   5'd18
`define ALU_OP_DIVU  5'd19
`define ALU_OP_MFHI  5'd20
`define ALU_OP_MFLO  5'd21
`define ALU_OP_MTHI  5'd22
`define ALU_OP_MTLO  5'd23
`endif

module tb_stage_execute_md;

    localparam logic [`ALU_OP_LEN-1:0] T_MULT  = `ALU_OP_MULT;
    localparam logic [`ALU_OP_LEN-1:0] T_MULTU = `ALU_OP_MULTU;
    localparam logic [`ALU_OP_LEN-1:0] T_DIV   = `ALU_OP_DIV;
    localparam logic [`ALU_OP_LEN-1:0] T_DIVU  = `ALU_OP_DIVU;
    localparam logic [`ALU_OP_LEN-1:0] T_MFHI  = `ALU_OP_MFHI;
    localparam logic [`ALU_OP_LEN-1:0] T_MFLO  = `ALU_OP_MFLO;
    localparam logic [`ALU_OP_LEN-1:0] T_MTHI  = `ALU_OP_MTHI;
    localparam logic [`ALU_OP_LEN-1:0] T_MTLO  = `ALU_OP_MTLO;
    localparam logic [`ALU_OP_LEN-1:0] T_ADD   = '0;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [`ALU_OP_LEN-1:0] op;
    logic                   op_valid;
    logic                   cancel;
    logic [31:0]            rs_data;
    logic [31:0]            rt_data;
    logic                   md_stall;
    logic                   busy;
    logic [31:0]            hi;
    logic [31:0]            lo;
    logic [31:0]            read_data;

    int checks   = 0;
    int failures = 0;

    stage_execute_md #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .op_valid(op_valid), .cancel(cancel),
        .rs_data(rs_data), .rt_data(rt_data), .md_stall(md_stall), .busy(busy),
        .hi(hi), .lo(lo), .read_data(read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [`ALU_OP_LEN-1:0] v_op;
        logic [31:0]            v_rs;
        logic [31:0]            v_rt;
        logic [31:0]            v_hi;
        logic [31:0]            v_lo;
        int                     v_cycles;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [`ALU_OP_LEN-1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        op = o; rs_data = a; rt_data = b; cancel = c; op_valid = 1'b1;
        tick();
        op_valid = 1'b0; cancel = 1'b0; op = T_ADD;
        #1;
    endtask

    // Ticks until busy falls (bounded), returning the number of busy samples seen.
    task automatic drain(output int n);
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        reset_n = 1'b0; op = T_ADD; op_valid = 1'b0; cancel = 1'b0;
        rs_data = '0; rt_data = '0;

        vecs[0]  = '{T_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[1]  = '{T_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{T_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{T_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFD, 0};
        vecs[4]  = '{T_MTLO,  32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0};
        vecs[5]  = '{T_DIVU,  32'h00000064, 32'd0,        32'h00001234, 32'h00005678, 10};
        vecs[6]  = '{T_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[7]  = '{T_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[8]  = '{T_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vecs[9]  = '{T_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[10] = '{T_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        10};
        vecs[11] = '{T_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 5};

        tick(); tick();
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].v_op, vecs[i].v_rs, vecs[i].v_rt, 1'b0);
            drain(n);
            chk($sformatf("vec%0d_cycles", i), n, vecs[i].v_cycles);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].v_hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].v_lo);
        end

        // hi/lo must hold their old value through the whole busy window.
        issue(T_MULT, 32'd3, 32'd3, 1'b0);
        repeat (4) tick();
        chk("mult_last_busy", {31'd0, busy}, 32'd1);
        chk("mult_hold_lo", lo, 32'h23456780);
        tick();
        chk("mult_commit_busy", {31'd0, busy}, 32'd0);
        chk("mult_commit_lo", lo, 32'd9);
        chk("mult_commit_hi", hi, 32'd0);

        // DIV followed by MFLO held valid: stalled 10 cycles, then reads the quotient.
        issue(T_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        op = T_MFLO; op_valid = 1'b1;
        #1;
        n = 0;
        while (md_stall && n < 20) begin
            n++;
            tick();
        end
        chk("mflo_stall_cycles", n, 10);
        chk("mflo_read", read_data, 32'hFFFFFFFD);
        chk("mflo_hi", hi, 32'hFFFFFFFF);
        op = T_MFHI; #1;
        chk("mfhi_read", read_data, 32'hFFFFFFFF);
        op = T_ADD; #1;
        chk("add_read_zero", read_data, 32'd0);
        chk("add_no_stall", {31'd0, md_stall}, 32'd0);
        tick();
        op_valid = 1'b0;
        chk("add_no_change_lo", lo, 32'hFFFFFFFD);

        // MT followed immediately by MF sees the new value.
        issue(T_MTHI, 32'hCAFE0001, 32'd0, 1'b0);
        op = T_MFHI; op_valid = 1'b1; #1;
        chk("mthi_then_mfhi", read_data, 32'hCAFE0001);
        op_valid = 1'b0; op = T_ADD;

        // Cancelled ops must not start or write.
        issue(T_MULT, 32'd5, 32'd5, 1'b1);
        chk("cancel_mult_busy", {31'd0, busy}, 32'd0);
        chk("cancel_mult_lo", lo, 32'hFFFFFFFD);
        issue(T_MTHI, 32'h0BAD0BAD, 32'd0, 1'b1);
        chk("cancel_mthi_hi", hi, 32'hCAFE0001);

        // Cancel during an in-flight DIV does not abort it.
        issue(T_DIVU, 32'd50, 32'd8, 1'b0);
        cancel = 1'b1; op = T_MULT; op_valid = 1'b1;
        tick(); tick();
        cancel = 1'b0; op_valid = 1'b0; op = T_ADD;
        drain(n);
        chk("cancel_inflight_cycles", n, 8);
        chk("cancel_inflight_lo", lo, 32'd6);
        chk("cancel_inflight_hi", hi, 32'd2);

        // Reset in cycle 3 of a DIV discards the result.
        issue(T_DIV, 32'd100, 32'd3, 1'b0);
        tick();
        reset_n = 1'b0;
        tick();
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        reset_n = 1'b1;
        repeat (12) tick();
        chk("postreset_busy", {31'd0, busy}, 32'd0);
        chk("postreset_lo", lo, 32'd0);
        chk("postreset_hi", hi, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_execute_md.md
Name: stage_execute_md

Overview:
- Multiply/divide responder with HI/LO registers, sitting in the execute stage.
- Accepts the MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO alu_op codes emitted by the decode stage and produces the mfhi/mflo read value.
- Multi-cycle operations hold a busy counter. The block raises a stall request so the hazard unit freezes any later HI/LO instruction until the operation completes.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- op  in  `ALU_OP_LEN  ALU operation code of the instruction in execute.
- op_valid  in  1  execute holds a real, unstalled instruction this cycle.
- cancel  in  1  exception/interrupt flush; the instruction in execute must not commit.
- rs_data  in  32  forwarded rs operand.
- rt_data  in  32  forwarded rt operand.
- md_stall  out  1  request to stall decode/execute.
- busy  out  1  multi-cycle operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- read_data  out  32  HI for MFHI, LO for MFLO, otherwise 0 (combinational).

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - hi=0, lo=0, counter=0, busy=0, pending results=0.
  - Reset wins over every other input, including mid-operation; an in-flight result is discarded.
- md_class = op is one of MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- md_stall = op_valid & md_class & busy (combinational). A stalled op is not accepted.
- accept = op_valid & md_class & ~busy & ~cancel.
- Start (accept & op in MULT/MULTU/DIV/DIVU):
  - At the edge, latch the full result into pending_hi/pending_lo.
  - Load the 4-bit counter with MULT_CYCLES or DIV_CYCLES.
- Counter and commit:
  - busy = (counter != 0), registered-derived, so it is high for exactly N cycles after the start edge.
  - At each edge with counter != 0, decrement the counter.
  - On the edge where the counter goes 1 -> 0, copy pending into hi/lo.
  - busy drops in the same cycle hi/lo show the new value.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64 product.
  - MULTU: {hi,lo} = unsigned 32x32 -> 64 product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - DIVU: unsigned quotient in lo, remainder in hi.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
  - Divisor 0: the operation still runs DIV_CYCLES busy cycles, but hi/lo are left unchanged at commit.
- MTHI / MTLO (accepted): hi (or lo) = rs_data at the edge, no busy cycles.
  - A following MFHI/MFLO in the next cycle sees the new value.
- MFHI / MFLO: read_data reflects the current hi/lo in the same cycle and does not modify state.
- cancel:
  - Blocks acceptance in the cycle it is asserted: no start, no MT write.
  - Does not abort an operation already in flight; the committed instruction was older than the faulting one.
- Non-md ops, or op_valid=0: no state change, md_stall=0.
- The counter never wraps: it reloads only when idle, and decrements only when nonzero.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFD rt=7: busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFEB; busy falls on the same edge hi/lo update.
- MULTU rs=0xFFFFFFFF rt=2: after 5 cycles hi=0x00000001 lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 rt=2, then MFLO held valid next cycle:
  - md_stall=1 for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - MFLO accepted with read_data=0xFFFFFFFD.
- Division edge cases:
  - MTHI 0x1234, MTLO 0x5678, then DIVU rt=0: busy 10 cycles, hi=0x1234 and lo=0x5678 unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Cancel:
  - MULT with cancel=1 in its cycle: busy stays 0, hi/lo unchanged.
  - MTHI with cancel=1: hi unchanged.
  - cancel pulsed during an in-flight DIV: the result still commits.
- Reset mid-operation: reset_n=0 at cycle 3 of a DIV forces busy=0, hi=lo=0; nothing commits afterward.
